freq_meter_nch: RTL and testbench



---
 rtl/freq_meter_pkg.sv | 28 ++
 rtl/freq_meter_nch_sync.sv | 33 +++
 rtl/freq_meter_nch.sv | 155 +++++++++++++++
 tb/tb_freq_meter_nch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants for the multi-channel gated frequency meter: FSM states,
// gate_sel encodings and the elaboration-time gate-length helpers.
package freq_meter_pkg;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_GATE = 1'b1;

    localparam logic [1:0] GSEL_DIV1    = 2'd0;
    localparam logic [1:0] GSEL_DIV10   = 2'd1;
    localparam logic [1:0] GSEL_DIV100  = 2'd2;
    localparam logic [1:0] GSEL_DIV1000 = 2'd3;

    function automatic int unsigned gate_len(input int unsigned clk_hz, input logic [1:0] sel);
        case (sel)
            GSEL_DIV1:    return clk_hz;
            GSEL_DIV10:   return clk_hz / 10;
            GSEL_DIV100:  return clk_hz / 100;
            default:      return clk_hz / 1000;
        endcase
    endfunction

    // The timer only ever reaches gate_len-1, and the longest gate is clk_hz cycles.
    function automatic int unsigned timer_w(input int unsigned clk_hz);
        return (clk_hz < 2) ? 1 : $clog2(clk_hz);
    endfunction

endpackage

// File: rtl/freq_meter_nch_sync.sv
// Per-pin synchroniser chain, previous-value flop and rising-edge pulse.
module sync_edge_det
    import freq_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign edge_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter_nch.sv
// Multi-channel gated frequency counter: counts synchronised rising edges per
// channel over back-to-back gate windows and latches saturated results.
//   state   | meaning
//   ST_IDLE | no gate open, accumulators cleared, gate_sel tracked
//   ST_GATE | gate open, timer running, edges accumulated
module freq_meter_nch
    import freq_meter_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned CW          = 27,
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        gate_sel,
    input  logic [NCH-1:0]    sig_in,
    output logic [NCH*CW-1:0] count_out,
    output logic [NCH-1:0]    overflow,
    output logic              valid,
    output logic              busy
);

    localparam int unsigned TW = timer_w(CLK_HZ);
    localparam int unsigned MW = $clog2(SYNC_STAGES + 2);
    localparam logic [TW-1:0] TERM_DIV1    = TW'(gate_len(CLK_HZ, GSEL_DIV1) - 1);
    localparam logic [TW-1:0] TERM_DIV10   = TW'(gate_len(CLK_HZ, GSEL_DIV10) - 1);
    localparam logic [TW-1:0] TERM_DIV100  = TW'(gate_len(CLK_HZ, GSEL_DIV100) - 1);
    localparam logic [TW-1:0] TERM_DIV1000 = TW'(gate_len(CLK_HZ, GSEL_DIV1000) - 1);

    // The shortest gate is the /1000 one; a gate under 2 cycles cannot open and close.
    if (gate_len(CLK_HZ, GSEL_DIV1000) < 2) begin : g_gate_len_err
        $error("freq_meter_nch: CLK_HZ too small, shortest gate below 2 cycles");
    end
    if (SYNC_STAGES < 2) begin : g_sync_err
        $error("freq_meter_nch: SYNC_STAGES must be at least 2");
    end

    logic [NCH-1:0] edge_raw, edge_m, sat;
    logic [NCH-1:0][CW-1:0] sum;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk      (clk),
            .reset    (reset),
            .sig_in   (sig_in[k]),
            .edge_out (edge_raw[k])
        );
    end

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d, term;
    logic [1:0]             sel_q, sel_d;
    logic [NCH-1:0][CW-1:0] acc_q, acc_d, cnt_q, cnt_d;
    logic [NCH-1:0]         acc_ovf_q, acc_ovf_d, ovf_q, ovf_d;
    logic                   valid_q, valid_d;
    logic [MW-1:0]          mask_q, mask_d;
    logic                   mask_done;

    // Hide edges until the sync chain and prev flop hold real pin history.
    assign mask_done = (mask_q == MW'(SYNC_STAGES + 1));
    assign edge_m    = mask_done ? edge_raw : '0;

    always_comb begin
        case (sel_q)
            GSEL_DIV1:   term = TERM_DIV1;
            GSEL_DIV10:  term = TERM_DIV10;
            GSEL_DIV100: term = TERM_DIV100;
            default:     term = TERM_DIV1000;
        endcase
    end

    always_comb begin
        sat = '0;
        sum = acc_q;
        for (int k = 0; k < NCH; k++) begin
            sat[k] = edge_m[k] & (acc_q[k] == {CW{1'b1}});
            sum[k] = sat[k] ? acc_q[k] : acc_q[k] + CW'(edge_m[k]);
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        sel_d     = sel_q;
        acc_d     = acc_q;
        acc_ovf_d = acc_ovf_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;
        mask_d    = mask_done ? mask_q : mask_q + MW'(1);
        case (state_q)
            ST_IDLE: begin
                timer_d   = '0;
                acc_d     = '0;
                acc_ovf_d = '0;
                sel_d     = gate_sel;
                if (enable) state_d = ST_GATE;
            end
            ST_GATE: begin
                if (timer_q == term) begin
                    cnt_d     = sum;
                    ovf_d     = acc_ovf_q | sat;
                    valid_d   = 1'b1;
                    acc_d     = '0;
                    acc_ovf_d = '0;
                    timer_d   = '0;
                    sel_d     = gate_sel;
                    state_d   = enable ? ST_GATE : ST_IDLE;
                end else if (!enable) begin
                    acc_d     = '0;
                    acc_ovf_d = '0;
                    timer_d   = '0;
                    state_d   = ST_IDLE;
                end else begin
                    acc_d     = sum;
                    acc_ovf_d = acc_ovf_q | sat;
                    timer_d   = timer_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            sel_q     <= '0;
            acc_q     <= '0;
            acc_ovf_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= '0;
            valid_q   <= 1'b0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            sel_q     <= sel_d;
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            mask_q    <= mask_d;
        end
    end

    assign count_out = cnt_q;
    assign overflow  = ovf_q;
    assign valid     = valid_q;
    assign busy      = (state_q == ST_GATE);

endmodule

// File: tb/tb_freq_meter_nch.sv
// Bench for freq_meter_nch: directed scenarios plus a randomized phase, all
// checked every cycle against a window-counting reference model.
module tb_freq_meter_nch;

    localparam int NCH    = 4;
    localparam int CW     = 4;
    localparam int CLK_HZ = 10000;
    localparam int S      = 2;
    localparam int MAXC   = 8192;
    localparam int CMAX   = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [1:0]        gate_sel;
    logic [NCH-1:0]    sig_in;
    logic [NCH*CW-1:0] count_out;
    logic [NCH-1:0]    overflow;
    logic              valid;
    logic              busy;

    always #5 clk = ~clk;

    freq_meter_nch #(
        .NCH(NCH), .CW(CW), .CLK_HZ(CLK_HZ), .SYNC_STAGES(S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .gate_sel  (gate_sel),
        .sig_in    (sig_in),
        .count_out (count_out),
        .overflow  (overflow),
        .valid     (valid),
        .busy      (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = -1;

    // stimulus settings
    bit       rst_v, en_v;
    int       sel_v;
    int       mode [NCH];
    int       per  [NCH];
    int       phase[NCH];
    bit       lvl  [NCH];
    int       pulse_at[NCH];
    bit       hist[NCH][MAXC];

    // reference model state
    bit       m_active;
    int       m_start, m_len, m_rst_end;
    int       e_cnt[NCH];
    bit       e_ovf[NCH];
    bit       e_valid;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int glen(input int sel);
        return CLK_HZ / (10 ** sel);
    endfunction

    // Rising pin transitions whose synchronised pulse lands in cycles [a,b].
    function automatic int rises(input int ch, input int a, input int b);
        int c = 0;
        for (int m = a; m <= b; m++) begin
            if (m - S - 1 >= m_rst_end) begin
                if (hist[ch][m-S] && !hist[ch][m-S-1]) c++;
            end
        end
        return c;
    endfunction

    task automatic tick();
        int r;
        bit s;
        @(negedge clk);
        cyc++;
        check("valid", valid, e_valid);
        check("busy", busy, m_active);
        for (int ch = 0; ch < NCH; ch++) begin
            check($sformatf("count[%0d]", ch), count_out[ch*CW +: CW], e_cnt[ch]);
            check($sformatf("ovf[%0d]", ch), overflow[ch], e_ovf[ch]);
        end
        for (int ch = 0; ch < NCH; ch++) begin
            case (mode[ch])
                0:       s = lvl[ch];
                1:       s = ((cyc + phase[ch]) % per[ch]) < (per[ch] / 2);
                default: s = 1'($urandom_range(0, 1));
            endcase
            if (cyc == pulse_at[ch]) s = 1'b1;
            sig_in[ch]    = s;
            hist[ch][cyc] = s;
        end
        reset    = rst_v;
        enable   = en_v;
        gate_sel = 2'(sel_v);
        // predict the outputs of the next cycle
        if (rst_v) begin
            m_active  = 1'b0;
            m_rst_end = cyc + 1;
            e_valid   = 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin e_cnt[ch] = 0; e_ovf[ch] = 1'b0; end
        end else if (!m_active) begin
            e_valid = 1'b0;
            if (en_v) begin m_active = 1'b1; m_start = cyc + 1; m_len = glen(sel_v); end
        end else if (cyc == m_start + m_len - 1) begin
            for (int ch = 0; ch < NCH; ch++) begin
                r = rises(ch, m_start, cyc);
                e_cnt[ch] = (r > CMAX) ? CMAX : r;
                e_ovf[ch] = (r > CMAX);
            end
            e_valid = 1'b1;
            if (en_v) begin m_start = cyc + 1; m_len = glen(sel_v); end
            else m_active = 1'b0;
        end else begin
            e_valid = 1'b0;
            if (!en_v) m_active = 1'b0;
        end
    endtask

    task automatic wait_valid(input int maxc, output int vc);
        vc = -1;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (valid) begin vc = cyc; break; end
        end
        if (vc < 0) check("valid_timeout", 0, 1);
    endtask

    initial begin
        int v0, v1, v2, prev0, nvalid;
        reset = 1'b1; enable = 1'b0; gate_sel = 2'd2; sig_in = 4'b1000;
        rst_v = 1'b1; en_v = 1'b0; sel_v = 2;
        mode  = '{1, 1, 0, 0};
        per   = '{10, 2, 2, 2};
        phase = '{0, 0, 0, 0};
        lvl   = '{0, 0, 0, 1};
        pulse_at = '{-1, -1, -1, -1};
        m_active = 1'b0; m_start = 0; m_len = 1; m_rst_end = 0; e_valid = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin e_cnt[ch] = 0; e_ovf[ch] = 1'b0; end

        // reset with ch3 already high, then run 100-cycle gates
        repeat (5) tick();
        rst_v = 1'b0; en_v = 1'b1;
        wait_valid(300, v0);
        check("first_valid_latency", v0 - m_rst_end, 101);
        check("ch0_period10", count_out[0*CW +: CW], 10);
        check("ch1_saturated", count_out[1*CW +: CW], CMAX);
        check("ch1_overflow", overflow[1], 1);
        check("ch2_low", count_out[2*CW +: CW], 0);
        check("ch3_high_at_reset", count_out[3*CW +: CW], 0);
        wait_valid(300, v1);
        check("gate_len_100", v1 - v0, 100);

        // gate_sel change mid-gate applies only to the following gate
        repeat (40) tick();
        sel_v = 3;
        wait_valid(300, v2);
        check("gate_len_kept", v2 - v1, 100);
        wait_valid(300, v1);
        check("gate_len_10", v1 - v2, 10);
        check("ch0_short_gate", count_out[0*CW +: CW], 1);

        // disable at timer=50 of a 100-cycle gate
        sel_v = 2;
        wait_valid(300, v0);
        while (cyc + 1 < m_start + 50) tick();
        prev0 = count_out[0*CW +: CW];
        en_v = 1'b0;
        tick();
        tick();
        check("busy_after_disable", busy, 0);
        check("count_kept", count_out[0*CW +: CW], prev0);
        nvalid = 0;
        for (int i = 0; i < 120; i++) begin tick(); if (valid) nvalid++; end
        check("no_valid_idle", nvalid, 0);
        en_v = 1'b1;
        wait_valid(300, v0);
        check("fresh_gate_ch0", count_out[0*CW +: CW], 10);

        // single pulse landing on the terminal cycle
        pulse_at[2] = m_start + m_len - 1 - S;
        wait_valid(300, v0);
        check("terminal_edge_closing", count_out[2*CW +: CW], 1);
        wait_valid(300, v0);
        check("terminal_edge_next", count_out[2*CW +: CW], 0);

        // reset mid-gate
        repeat (30) tick();
        rst_v = 1'b1;
        tick();
        rst_v = 1'b0;
        tick();
        check("rst_count0", count_out[0*CW +: CW], 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);
        wait_valid(300, v0);
        check("ch3_after_reset", count_out[3*CW +: CW], 0);

        // randomized phase
        for (int blk = 0; blk < 6; blk++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                mode[ch]  = $urandom_range(0, 2);
                per[ch]   = $urandom_range(2, 13);
                phase[ch] = $urandom_range(0, 12);
                lvl[ch]   = 1'($urandom_range(0, 1));
            end
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 199) == 0) en_v = ~en_v;
                if ($urandom_range(0, 49) == 0) sel_v = $urandom_range(1, 3);
                rst_v = ($urandom_range(0, 1499) == 0);
                tick();
            end
        end
        rst_v = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
